keypad_entry_encoder: RTL and testbench

- Parametrised successor to the microwave numpad priority encoder.
- Synchronises and debounces an N-key one-hot/multi-hot keypad and priority-encodes it to a binary key code.
- Each debounced press produces exactly one event (active-low loadn pulse plus key_valid pulse), shifted into a DIGITS-deep BCD entry register that feeds the timer input control.
- Holding a key generates no repeat events; keys must be released before the next press is accepted.

---
 rtl/keypad_entry_encoder.sv | 161 ++++++++++++++++
 tb/tb_keypad_entry_encoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_encoder.sv
// Keypad front end: synchronises and debounces N raw key lines, priority-encodes
// the highest pressed key, and shifts one digit per press into a BCD entry register.
module keypad_entry_encoder #(
    parameter int N_KEYS          = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enablen,
    input  logic [N_KEYS-1:0]            teclado_microondas,
    input  logic                         clear_entry,
    output logic [CODE_W-1:0]            saida_cod,
    output logic                         loadn,
    output logic                         key_valid,
    output logic [DIGITS*CODE_W-1:0]     entry_digits,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         entry_full
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DCNT_W  = $clog2(DIGITS + 1);
    localparam int ENTRY_W = DIGITS * CODE_W;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [DCNT_W-1:0] DIGITS_MAX = DCNT_W'(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD
    } state_t;

    // Highest-index set line wins; an all-zero input encodes to 0 but is never accepted.
    function automatic logic [CODE_W-1:0] prio_code(input logic [N_KEYS-1:0] keys);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (keys[i]) code = CODE_W'(i);
        end
        return code;
    endfunction

    logic [N_KEYS-1:0] sync_p0;
    logic [N_KEYS-1:0] sync_p1;
    logic              ks_any;
    logic [CODE_W-1:0] ks_code;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic              accept;

    // Stage p0/p1: two-flop synchroniser for the asynchronous key lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= teclado_microondas;
            sync_p1 <= sync_p0;
        end
    end

    assign ks_any  = |sync_p1;
    assign ks_code = prio_code(sync_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // cnt counts matching press samples in DEBOUNCE and quiet samples in HELD
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (enablen) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ks_any) begin
                        cand_d  = ks_code;
                        cnt_d   = CNT_ONE;
                        state_d = DEBOUNCE;
                        if (CNT_LAST == CNT_ONE) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (ks_any && ks_code == cand_q) begin
                        if (cnt_q + CNT_ONE == CNT_LAST) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (!ks_any) begin
                        if (cnt_q + CNT_ONE == CNT_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Event and entry register: a clear wins over a simultaneous digit push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid    <= 1'b0;
            saida_cod    <= '0;
            entry_digits <= '0;
            digit_count  <= '0;
        end else begin
            key_valid <= accept;
            if (accept) saida_cod <= cand_d;
            if (clear_entry) begin
                entry_digits <= '0;
                digit_count  <= '0;
            end else if (accept && digit_count < DIGITS_MAX) begin
                entry_digits <= (entry_digits << CODE_W) | ENTRY_W'(cand_d);
                digit_count  <= digit_count + DCNT_W'(1);
            end
        end
    end

    assign loadn      = ~key_valid;
    assign entry_full = (digit_count == DIGITS_MAX);

endmodule

// File: tb/tb_keypad_entry_encoder.sv
// Directed bench for keypad_entry_encoder: a press/release behavioural model checked
// every cycle, plus literal expectations for each scenario.
module tb_keypad_entry_encoder;

    localparam int N_KEYS = 10;
    localparam int CODE_W = 4;
    localparam int D      = 4;
    localparam int DIGITS = 4;

    logic                    clk;
    logic                    rst;
    logic                    enablen;
    logic [N_KEYS-1:0]       keys;
    logic                    clear_entry;
    logic [CODE_W-1:0]       saida_cod;
    logic                    loadn;
    logic                    key_valid;
    logic [DIGITS*CODE_W-1:0] entry_digits;
    logic [2:0]              digit_count;
    logic                    entry_full;

    int total;
    int bad;
    int ev_cnt;
    int ev0;
    bit chk_en;

    keypad_entry_encoder #(
        .N_KEYS(N_KEYS), .CODE_W(CODE_W), .DEBOUNCE_CYCLES(D), .DIGITS(DIGITS)
    ) dut (
        .clk(clk), .rst(rst), .enablen(enablen), .teclado_microondas(keys),
        .clear_entry(clear_entry), .saida_cod(saida_cod), .loadn(loadn),
        .key_valid(key_valid), .entry_digits(entry_digits),
        .digit_count(digit_count), .entry_full(entry_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the key as "armed" (waiting for a stable press) or "held" (waiting
    // for a stable release); digits kept as a queue, oldest first.
    int m_s1, m_s2;
    bit m_held;
    int m_run, m_quiet, m_cand;
    bit m_kv;
    int m_code;
    int m_dig[$];
    bit m_acc;

    function automatic int top_key(input int v);
        int idx;
        idx = -1;
        while (v != 0) begin
            v = v >> 1;
            idx++;
        end
        return idx;
    endfunction

    function automatic int model_entry();
        int v;
        v = 0;
        foreach (m_dig[i]) v = (v << CODE_W) + m_dig[i];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_held = 0; m_run = 0; m_quiet = 0;
            m_cand = 0; m_kv = 0; m_code = 0;
            m_dig.delete();
        end else begin
            m_acc = 0;
            m_kv  = 0;
            if (enablen) begin
                m_held = 0; m_run = 0; m_quiet = 0;
            end else if (m_held) begin
                if (m_s2 == 0) begin
                    m_quiet++;
                    if (m_quiet == D) begin
                        m_held = 0;
                        m_quiet = 0;
                    end
                end else begin
                    m_quiet = 0;
                end
            end else if (m_run == 0) begin
                if (m_s2 != 0) begin
                    m_cand = top_key(m_s2);
                    m_run  = 1;
                end
            end else if (m_s2 != 0 && top_key(m_s2) == m_cand) begin
                m_run++;
            end else begin
                m_run = 0;
            end
            if (!enablen && !m_held && m_run == D) m_acc = 1;
            if (m_acc) begin
                m_kv = 1; m_code = m_cand; m_held = 1; m_run = 0; m_quiet = 0;
                if (!clear_entry && m_dig.size() < DIGITS) m_dig.push_back(m_cand);
            end
            if (clear_entry) m_dig.delete();
            m_s2 = m_s1;
            m_s1 = int'(keys);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("key_valid", int'(key_valid), int'(m_kv));
            check("loadn", int'(loadn), int'(!m_kv));
            check("saida_cod", int'(saida_cod), m_code);
            check("entry_digits", int'(entry_digits), model_entry());
            check("digit_count", int'(digit_count), m_dig.size());
            check("entry_full", int'(entry_full), int'(m_dig.size() == DIGITS));
        end
        if (key_valid === 1'b1) ev_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press_release(input int k);
        keys = N_KEYS'(1 << k);
        step(8);
        keys = '0;
        step(8);
    endtask

    initial begin
        total = 0; bad = 0; ev_cnt = 0; chk_en = 0;
        rst = 1'b1; enablen = 1'b0; clear_entry = 1'b0; keys = '0;
        step(2);
        chk_en = 1;
        step(1);
        check("reset_key_valid", int'(key_valid), 0);
        check("reset_loadn", int'(loadn), 1);
        check("reset_code", int'(saida_cod), 0);
        check("reset_entry", int'(entry_digits), 0);
        check("reset_count", int'(digit_count), 0);
        check("reset_full", int'(entry_full), 0);

        // Single press: pulse exactly in the cycle after edge D+2
        rst = 1'b0;
        keys = 10'b0000000100;
        ev0 = ev_cnt;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("latency_kv_e%0d", e), int'(key_valid), int'(e == 6));
            check($sformatf("latency_loadn_e%0d", e), int'(loadn), int'(e != 6));
        end
        @(posedge clk);
        #2;
        check("setup_events", ev_cnt - ev0, 1);
        check("setup_code", int'(saida_cod), 2);
        check("setup_entry", int'(entry_digits), 16'h0002);
        check("setup_count", int'(digit_count), 1);
        check("model_setup_code", m_code, 2);
        check("model_setup_entry", model_entry(), 16'h0002);
        keys = '0;
        step(8);

        // Bouncing contact never settles long enough, then a clean press
        ev0 = ev_cnt;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 10'b0000100000 : 10'b0;
            step(2);
        end
        check("bounce_no_event", ev_cnt - ev0, 0);
        keys = 10'b0000100000;
        step(12);
        check("bounce_events", ev_cnt - ev0, 1);
        check("bounce_code", int'(saida_cod), 5);
        check("bounce_entry", int'(entry_digits), 16'h0025);
        keys = '0;
        step(8);

        // Two keys: highest wins; extra key while held is ignored
        ev0 = ev_cnt;
        keys = 10'b0000001001;
        step(10);
        check("multi_events", ev_cnt - ev0, 1);
        check("multi_code", int'(saida_cod), 3);
        keys = 10'b1000001001;
        step(10);
        check("held_no_repeat", ev_cnt - ev0, 1);
        keys = '0;
        step(8);
        keys = 10'b1000000000;
        step(10);
        check("key9_events", ev_cnt - ev0, 2);
        check("key9_code", int'(saida_cod), 9);
        check("key9_entry", int'(entry_digits), 16'h2539);
        check("key9_full", int'(entry_full), 1);
        keys = '0;
        step(8);
        clear_entry = 1'b1;
        step(1);
        clear_entry = 1'b0;
        check("clear1_entry", int'(entry_digits), 0);
        check("clear1_count", int'(digit_count), 0);
        check("clear1_full", int'(entry_full), 0);

        // Fill the entry, then overflow press leaves it untouched
        for (int k = 1; k <= 4; k++) press_release(k);
        check("fill_entry", int'(entry_digits), 16'h1234);
        check("fill_full", int'(entry_full), 1);
        check("model_fill_entry", model_entry(), 16'h1234);
        ev0 = ev_cnt;
        press_release(5);
        check("over_events", ev_cnt - ev0, 1);
        check("over_code", int'(saida_cod), 5);
        check("over_entry", int'(entry_digits), 16'h1234);
        check("over_count", int'(digit_count), 4);
        clear_entry = 1'b1;
        step(1);
        clear_entry = 1'b0;
        check("clear2_entry", int'(entry_digits), 0);
        check("clear2_count", int'(digit_count), 0);

        // Clear held across an accept: event fires, nothing stored
        ev0 = ev_cnt;
        clear_entry = 1'b1;
        keys = 10'b0010000000;
        step(10);
        clear_entry = 1'b0;
        check("clracc_events", ev_cnt - ev0, 1);
        check("clracc_code", int'(saida_cod), 7);
        check("clracc_count", int'(digit_count), 0);
        keys = '0;
        step(8);

        // Disabled keypad blocks events; enabling with key held gives one
        ev0 = ev_cnt;
        enablen = 1'b1;
        keys = 10'b0000000010;
        step(20);
        check("disabled_events", ev_cnt - ev0, 0);
        check("disabled_code", int'(saida_cod), 7);
        check("disabled_entry", int'(entry_digits), 0);
        enablen = 1'b0;
        step(10);
        check("enable_events", ev_cnt - ev0, 1);
        check("enable_code", int'(saida_cod), 1);
        check("enable_entry", int'(entry_digits), 16'h0001);
        keys = '0;
        step(8);

        // Reset during the third debounce cycle, then re-press
        ev0 = ev_cnt;
        keys = 10'b0000001000;
        step(5);
        rst = 1'b1;
        #1;
        check("midrst_key_valid", int'(key_valid), 0);
        check("midrst_loadn", int'(loadn), 1);
        check("midrst_code", int'(saida_cod), 0);
        check("midrst_entry", int'(entry_digits), 0);
        check("midrst_count", int'(digit_count), 0);
        step(2);
        check("midrst_no_event", ev_cnt - ev0, 0);
        rst = 1'b0;
        step(12);
        check("postrst_events", ev_cnt - ev0, 1);
        check("postrst_code", int'(saida_cod), 3);
        check("postrst_entry", int'(entry_digits), 16'h0003);
        keys = '0;
        step(8);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
